alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one combinational ALU instance (ops ADD/SUB/AND/OR/SLL, 4-bit opcode, 5-bit shift amount, carry flag) between NUM_REQ requesters.
- Uses round-robin arbitration and a registered command path to the ALU.
- Returns the captured result with the requester ID on a valid/ready response channel.
- Sits between requesting datapath masters and the ALU; the ALU is instantiated outside this block.

Parameters:
- WIDTH, 128, operand/result width in bits.
- NUM_REQ, 4, number of requesters (>=2).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_opcode  input  NUM_REQ*4  flattened opcodes; requester i at [4i+3:4i].
- req_a  input  NUM_REQ*WIDTH  flattened operand 1.
- req_b  input  NUM_REQ*WIDTH  flattened operand 2.
- req_shamt  input  NUM_REQ*5  flattened shift amounts.
- alu_opcode  output  4  registered opcode to ALU.
- alu_in1  output  WIDTH  registered operand 1 to ALU.
- alu_in2  output  WIDTH  registered operand 2 to ALU.
- alu_shift  output  5  registered shift amount to ALU.
- alu_result  input  WIDTH  ALU result (combinational from alu_* outputs).
- alu_carry  input  1  ALU carry/borrow.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  ID_W  index of the requester that issued the op.
- rsp_result  output  WIDTH  captured result.
- rsp_carry  output  1  captured carry; 0 for non-ADD/SUB ops.
- rsp_err  output  1  illegal-opcode flag (see Optional Feature).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset is async and active high. On reset:
  - state=IDLE.
  - All outputs 0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-operation abandons the in-flight op: no response is produced and the ALU command regs clear to 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, accept window:
  - If any req_valid, the arbiter picks the first valid index scanning last_grant+1 upward with wrap-around.
  - req_ready[g]=1 combinationally in the same cycle; the transfer occurs on valid&ready.
  - At the clock edge: latch opcode/a/b/shamt of g into the alu_* regs, rsp_id<=g, last_grant<=g, go to EXEC.
  - With no valid request, stay in IDLE with req_ready=0.
- EXEC: alu_* stable for exactly one cycle. At the edge:
  - rsp_result<=alu_result.
  - rsp_carry<=alu_carry if opcode is ADD(0) or SUB(1), else 0.
  - rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_result, rsp_carry and rsp_err are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, the same cycle also acts as an accept window (arbitration as in IDLE; req_ready asserted only when rsp_ready=1).
    - If a grant occurs: go to EXEC, and rsp_valid drops next cycle.
    - Otherwise: go to IDLE.
  - Without rsp_ready, req_ready=0.
- Latency: accept edge to rsp_valid = 2 cycles. Back-to-back throughput is 1 op per 2 cycles with rsp_ready held high.
- req_ready is never asserted to a requester whose req_valid is 0. At most one bit is set.
- Requests are not dropped. A requester holds valid and payload until ready.
- A requester deasserting valid before grant is legal; the arbiter re-evaluates each cycle.
- rsp_carry for SUB is the ALU borrow bit as delivered. The block does not recompute it.

Optional Feature:
- Macro ALU_SCHED_OPCHECK_EN.
- Defined:
  - Opcodes 5..15 are accepted normally.
  - In EXEC, rsp_result<=0, rsp_carry<=0, rsp_err<=1.
  - alu_opcode is still driven; the ALU output is ignored.
- Undefined: rsp_err is tied 0 and every opcode passes through, with the result taken from the ALU (ALU default gives 0).

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SLL=4.
  - OP_W=4 and SHAMT_W=5.
  - The FSM state enum {IDLE, EXEC, RESP}.
- One sub-module, rr_arbiter (NUM_REQ parameter). Inputs: req vector, last_grant pointer. Outputs: one-hot grant, encoded index, any_grant. Purely combinational.

Test Plan:
- Single ADD:
  - Stimulus: req_valid=0001, a=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, alu model attached.
  - Response: req_ready[0] in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=0, rsp_carry=1.
- Round-robin fairness:
  - Stimulus: req_valid=1111 held, rsp_ready=1.
  - Response: grants in order 0,1,2,3,0. After reset the first grant is 0.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid, with requester 2 valid.
  - Response: rsp_* held stable, req_ready=0 throughout. On rsp_ready=1, requester 2 is granted in that same cycle.
- SLL and carry masking:
  - Stimulus: opcode=4, a=1, shamt=31, alu_carry forced to 1.
  - Response: rsp_result=32'h8000_0000 zero-extended, rsp_carry=0.
- Reset mid-EXEC:
  - Stimulus: assert rst asynchronously in EXEC.
  - Response: rsp_valid=0 and busy=0 immediately. After release, requester 0 has priority and no stale response appears.
- Illegal opcode:
  - Stimulus: opcode=9, with ALU_SCHED_OPCHECK_EN defined.
  - Response: rsp_err=1, rsp_result=0. With the macro undefined, rsp_err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, field widths and scheduler FSM state.
package alu_pkg;

    localparam int OP_W    = 4;
    localparam int SHAMT_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_SLL = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    function automatic logic has_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_SLL;
    endfunction

endpackage

// File: rtl/alu_rr_scheduler_arb.sv
// Combinational round-robin arbiter: first request after last_grant wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any_grant
);

    int j;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        j         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last_grant) + k) % NUM_REQ;
            if (!any_grant && req[j]) begin
                any_grant = 1'b1;
                idx       = ID_W'(j);
                grant[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external ALU between NUM_REQ requesters.
// Optional illegal-opcode checking enabled by defining ALU_SCHED_OPCHECK_EN.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*OP_W-1:0]    req_opcode,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
    output logic [OP_W-1:0]            alu_opcode,
    output logic [WIDTH-1:0]           alu_in1,
    output logic [WIDTH-1:0]           alu_in2,
    output logic [SHAMT_W-1:0]         alu_shift,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       alu_carry,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_carry,
    output logic                       rsp_err,
    output logic                       busy
);

    state_t              state;
    logic [ID_W-1:0]     last_grant;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gidx;
    logic                any;
    logic                win;
    logic                take;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_arb (
        .req       (req_valid),
        .last_grant(last_grant),
        .grant     (gnt),
        .idx       (gidx),
        .any_grant (any)
    );

    // A finished response frees the slot in the same cycle it is taken.
    assign win       = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign take      = win && any;
    assign req_ready = win ? gnt : '0;
    assign busy      = (state != IDLE);

`ifndef ALU_SCHED_OPCHECK_EN
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            alu_opcode <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_shift  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
`ifdef ALU_SCHED_OPCHECK_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    if (take) begin
                        alu_opcode <= req_opcode[int'(gidx)*OP_W +: OP_W];
                        alu_in1    <= req_a[int'(gidx)*WIDTH +: WIDTH];
                        alu_in2    <= req_b[int'(gidx)*WIDTH +: WIDTH];
                        alu_shift  <= req_shamt[int'(gidx)*SHAMT_W +: SHAMT_W];
                        rsp_id     <= gidx;
                        last_grant <= gidx;
                        rsp_valid  <= 1'b0;
                        state      <= EXEC;
                    end else if (win) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                EXEC: begin
`ifdef ALU_SCHED_OPCHECK_EN
                    if (!op_legal(alu_opcode)) begin
                        rsp_result <= '0;
                        rsp_carry  <= 1'b0;
                        rsp_err    <= 1'b1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_carry  <= has_carry(alu_opcode) & alu_carry;
                        rsp_err    <= 1'b0;
                    end
`else
                    rsp_result <= alu_result;
                    rsp_carry  <= has_carry(alu_opcode) & alu_carry;
`endif
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler with an attached ALU model.
module tb_alu_rr_scheduler;

    localparam int W  = 128;
    localparam int N  = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*4-1:0]   req_opcode;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*5-1:0]   req_shamt;
    logic [3:0]       alu_opcode;
    logic [W-1:0]     alu_in1;
    logic [W-1:0]     alu_in2;
    logic [4:0]       alu_shift;
    logic [W-1:0]     alu_result;
    logic             alu_carry;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [W-1:0]     rsp_result;
    logic             rsp_carry;
    logic             rsp_err;
    logic             busy;

    logic [3:0]       t_op[N];
    logic [W-1:0]     t_a[N];
    logic [W-1:0]     t_b[N];
    logic [4:0]       t_sh[N];
    logic             force_carry;
    logic [W:0]       wide;

    int total = 0;
    int bad   = 0;
    int last;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opcode(req_opcode),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_shamt (req_shamt),
        .alu_opcode(alu_opcode),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_shift (alu_shift),
        .alu_result(alu_result),
        .alu_carry (alu_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always_comb begin
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        req_shamt  = '0;
        for (int i = 0; i < N; i++) begin
            req_opcode[i*4 +: 4] = t_op[i];
            req_a[i*W +: W]      = t_a[i];
            req_b[i*W +: W]      = t_b[i];
            req_shamt[i*5 +: 5]  = t_sh[i];
        end
    end

    // External ALU: combinational from the registered command.
    always_comb begin
        wide = '0;
        case (alu_opcode)
            4'd0:    wide = {1'b0, alu_in1} + {1'b0, alu_in2};
            4'd1:    wide = {1'b0, alu_in1} - {1'b0, alu_in2};
            4'd2:    wide = {1'b0, alu_in1 & alu_in2};
            4'd3:    wide = {1'b0, alu_in1 | alu_in2};
            4'd4:    wide = {1'b0, alu_in1 << alu_shift};
            default: wide = '0;
        endcase
        alu_result = wide[W-1:0];
        alu_carry  = wide[W] | force_carry;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] m, input int lg);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (lg + k) % N;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input logic [N-1:0] m,
                                               input int lg);
        int g;
        g = pick(m, lg);
        return (g < 0) ? '0 : (N'(1) << g);
    endfunction

    // Expected result/carry from the operation's arithmetic meaning.
    task automatic ref_calc(input int r, output logic [W-1:0] res,
                            output logic c);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = t_a[r];
        b = t_b[r];
        res = '0;
        c   = 1'b0;
        case (t_op[r])
            4'd0: begin res = a + b; c = (res < a); end
            4'd1: begin res = a - b; c = (a < b); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a << t_sh[r];
            default: res = '0;
        endcase
    endtask

    task automatic rand_payload(input int i);
        t_op[i] = 4'($urandom_range(0, 4));
        t_a[i]  = {$urandom, $urandom, $urandom, $urandom};
        t_b[i]  = {$urandom, $urandom, $urandom, $urandom};
        t_sh[i] = 5'($urandom_range(0, 31));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] er;
        logic         ec;
        logic [N-1:0] m;
        int           g;
        int           nh;
        logic         exp_err;

        rst         = 1'b1;
        req_valid   = '0;
        rsp_ready   = 1'b0;
        force_carry = 1'b0;
        for (int i = 0; i < N; i++) begin
            t_op[i] = '0; t_a[i] = '0; t_b[i] = '0; t_sh[i] = '0;
        end
        tick();
        tick();
        chk("rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_req_ready", W'(req_ready), W'(0));
        chk("rst_alu_in1", alu_in1, W'(0));
        chk("rst_rsp_id", W'(rsp_id), W'(0));
        rst  = 1'b0;
        last = N - 1;

        // Single ADD with carry out
        t_op[0] = 4'd0;
        t_a[0]  = '1;
        t_b[0]  = W'(1);
        req_valid = 4'b0001;
        #1;
        chk("add_req_ready", W'(req_ready), W'(4'b0001));
        tick();
        req_valid = '0;
        last = 0;
        chk("add_busy", W'(busy), W'(1));
        chk("add_alu_in1", alu_in1, '1);
        chk("add_exec_novalid", W'(rsp_valid), W'(0));
        tick();
        chk("add_rsp_valid", W'(rsp_valid), W'(1));
        chk("add_rsp_id", W'(rsp_id), W'(0));
        chk("add_rsp_result", rsp_result, W'(0));
        chk("add_rsp_carry", W'(rsp_carry), W'(1));
        chk("add_rsp_err", W'(rsp_err), W'(0));
        rsp_ready = 1'b1;
        tick();
        chk("add_done_valid", W'(rsp_valid), W'(0));
        chk("add_done_busy", W'(busy), W'(0));

        // Round-robin fairness from reset
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        last = N - 1;
        for (int i = 0; i < N; i++) rand_payload(i);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_order", W'(req_ready), W'(N'(1) << (k % N)));
            g = k % N;
            ref_calc(g, er, ec);
            tick();
            last = g;
            tick();
            chk("rr_rsp_id", W'(rsp_id), W'(g));
            chk("rr_rsp_result", rsp_result, er);
            chk("rr_rsp_carry", W'(rsp_carry), W'(ec));
        end
        req_valid = '0;
        tick();

        // Response backpressure with requester 2 waiting
        t_op[1] = 4'd3;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        chk("bp_first_ready", W'(req_ready), exp_ready(4'b0010, last));
        ref_calc(1, er, ec);
        tick();
        last = 1;
        req_valid = 4'b0100;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", W'(rsp_valid), W'(1));
            chk("bp_hold_id", W'(rsp_id), W'(1));
            chk("bp_hold_result", rsp_result, er);
            chk("bp_no_ready", W'(req_ready), W'(0));
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_grant2_same_cycle", W'(req_ready), W'(4'b0100));
        ref_calc(2, er, ec);
        tick();
        req_valid = '0;
        last = 2;
        chk("bp_valid_drops", W'(rsp_valid), W'(0));
        tick();
        chk("bp_rsp2_id", W'(rsp_id), W'(2));
        chk("bp_rsp2_result", rsp_result, er);
        tick();

        // SLL with carry masking
        t_op[1] = 4'd4;
        t_a[1]  = W'(1);
        t_sh[1] = 5'd31;
        force_carry = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("sll_ready", W'(req_ready), W'(4'b0010));
        tick();
        req_valid = '0;
        last = 1;
        tick();
        chk("sll_result", rsp_result, W'(32'h8000_0000));
        chk("sll_carry", W'(rsp_carry), W'(0));
        force_carry = 1'b0;
        tick();

        // Asynchronous reset while in EXEC
        t_op[3] = 4'd2;
        t_a[3]  = {$urandom, $urandom, $urandom, 32'h1};
        req_valid = 4'b1000;
        #1;
        tick();
        req_valid = '0;
        chk("rstx_busy_pre", W'(busy), W'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rstx_valid", W'(rsp_valid), W'(0));
        chk("rstx_busy", W'(busy), W'(0));
        chk("rstx_alu_in1", alu_in1, W'(0));
        chk("rstx_alu_op", W'(alu_opcode), W'(0));
        #2;
        rst  = 1'b0;
        last = N - 1;
        tick();
        tick();
        chk("rstx_no_stale", W'(rsp_valid), W'(0));
        req_valid = '1;
        #1;
        chk("rstx_prio0", W'(req_ready), W'(4'b0001));
        ref_calc(0, er, ec);
        tick();
        req_valid = '0;
        last = 0;
        tick();
        chk("rstx_rsp_id", W'(rsp_id), W'(0));
        chk("rstx_rsp_result", rsp_result, er);
        tick();

        // Illegal opcode
        t_op[2] = 4'd9;
        t_a[2]  = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = '0;
        last = 2;
        tick();
`ifdef ALU_SCHED_OPCHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        chk("ill_err", W'(rsp_err), W'(exp_err));
        chk("ill_result", rsp_result, W'(0));
        chk("ill_carry", W'(rsp_carry), W'(0));
        tick();

        // Randomized traffic against the reference model
        rsp_ready = 1'b1;
        repeat (60) begin
            m = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) rand_payload(i);
            req_valid = m;
            #1;
            chk("rnd_ready", W'(req_ready), W'(exp_ready(m, last)));
            g = pick(m, last);
            if (g < 0) begin
                tick();
            end else begin
                ref_calc(g, er, ec);
                tick();
                last = g;
                req_valid = N'($urandom);
                rand_payload(g);
                tick();
                chk("rnd_valid", W'(rsp_valid), W'(1));
                chk("rnd_id", W'(rsp_id), W'(g));
                chk("rnd_result", rsp_result, er);
                chk("rnd_carry", W'(rsp_carry), W'(ec));
                nh = $urandom_range(0, 3);
                rsp_ready = 1'b0;
                for (int h = 0; h < nh; h++) begin
                    req_valid = N'($urandom);
                    #1;
                    chk("rnd_bp_ready", W'(req_ready), W'(0));
                    chk("rnd_bp_result", rsp_result, er);
                    tick();
                end
                rsp_ready = 1'b1;
            end
        end
        req_valid = '0;
        tick();
        tick();
        chk("end_idle", W'(busy), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
